// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: round-robin I/D arbiter for one single-port SRAM, with registered M_* command, I_*/D_* request and response ports and async reset RST
module sram_port_arbiter #(
  parameter int AWIDTH = 12
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              I_REQ,
  input  logic [AWIDTH-1:0] I_ADDR,
  output logic              I_GNT,
  output logic              I_RVALID,
  output logic [31:0]       I_RDATA,
  input  logic              D_REQ,
  input  logic              D_WE,
  input  logic [AWIDTH-1:0] D_ADDR,
  input  logic [3:0]        D_BE,
  input  logic [31:0]       D_WDATA,
  output logic              D_GNT,
  output logic              D_RVALID,
  output logic [31:0]       D_RDATA,
  output logic              M_CSN,
  output logic [AWIDTH-1:0] M_ADDR,
  output logic              M_WEN,
  output logic [3:0]        M_BE,
  output logic [31:0]       M_DI,
  input  logic [31:0]       M_DOUT
);
  logic r_last;
  logic r_tag_rd;
  logic r_tag_src;
  logic w_gnt_i;
  logic w_gnt_d;
  assign w_gnt_d = ~RST & D_REQ & (~I_REQ | ~r_last);
  assign w_gnt_i = ~RST & I_REQ & (~D_REQ | r_last);
  assign I_GNT = w_gnt_i;
  assign D_GNT = w_gnt_d;
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      r_last    <= 1'b0;
      r_tag_rd  <= 1'b0;
      r_tag_src <= 1'b0;
      M_CSN     <= 1'b1;
      M_WEN     <= 1'b1;
      M_ADDR    <= '0;
      M_BE      <= 4'h0;
      M_DI      <= 32'h0;
      I_RVALID  <= 1'b0;
      D_RVALID  <= 1'b0;
      I_RDATA   <= 32'h0;
      D_RDATA   <= 32'h0;
    end else begin
      if (w_gnt_i | w_gnt_d) r_last <= w_gnt_d;
      M_CSN <= ~(w_gnt_i | w_gnt_d);
      if (w_gnt_i) begin
        M_WEN  <= 1'b1;
        M_BE   <= 4'hF;
        M_ADDR <= I_ADDR;
      end else if (w_gnt_d) begin
        M_WEN  <= ~D_WE;
        M_BE   <= D_BE;
        M_DI   <= D_WDATA;
        M_ADDR <= D_ADDR;
      end
      r_tag_rd  <= w_gnt_i | (w_gnt_d & ~D_WE);
      r_tag_src <= w_gnt_d;
      I_RVALID  <= r_tag_rd & ~r_tag_src;
      D_RVALID  <= r_tag_rd & r_tag_src;
      if (r_tag_rd & ~r_tag_src) I_RDATA <= M_DOUT;
      if (r_tag_rd & r_tag_src) D_RDATA <= M_DOUT;
    end
endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Two-requester arbiter that shares one single-port 32-bit SRAM between the core's instruction-fetch port and its load/store port. It arbitrates round-robin on conflicts and drives the SRAM's active-low chip select and write enable, byte enables, address and write data from registers so the array never sees combinational glitches. It captures the SRAM's combinational read data into a per-port response register. It sits between the pipeline's I/D memory interfaces and the unified instruction/data SRAM.

## Interface
- AWIDTH, 12, word-address width; must equal the SRAM's address width.
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- I_REQ  in  1  instruction read request; held with I_ADDR until I_GNT.
- I_ADDR  in  AWIDTH  instruction word address.
- I_GNT  out  1  combinational; request accepted this cycle.
- I_RVALID  out  1  one-cycle pulse; I_RDATA is valid.
- I_RDATA  out  32  instruction read data; holds its value between pulses.
- D_REQ  in  1  data request; held with D_WE, D_ADDR, D_BE and D_WDATA until D_GNT.
- D_WE  in  1  1 = write, 0 = read (active-high).
- D_ADDR  in  AWIDTH  data word address.
- D_BE  in  4  byte enables for writes; bit n enables byte n.
- D_WDATA  in  32  write data.
- D_GNT  out  1  combinational; request accepted this cycle.
- D_RVALID  out  1  one-cycle pulse for data reads only.
- D_RDATA  out  32  data read result; holds its value between pulses.
- M_CSN  out  1  SRAM chip select, active-low, registered.
- M_ADDR  out  AWIDTH  SRAM address, registered.
- M_WEN  out  1  SRAM write enable, active-low (1 = read), registered.
- M_BE  out  4  SRAM byte enables, registered.
- M_DI  out  32  SRAM write data, registered.
- M_DOUT  in  32  SRAM read data; combinational from M_ADDR.

## Operation
- Stage A (arbitrate, cycle N):
  - Only I_REQ high: I_GNT=1.
  - Only D_REQ high: D_GNT=1.
  - Both high: grant the port not granted last (LAST pointer). At most one GNT per cycle.
- LAST updates only on a grant, to the port granted. The reset value of LAST is I, so D wins the first conflict.
- Stage M (SRAM access, cycle N+1):
  - At the edge ending cycle N, a granted request loads the M_* registers:
    - I grant: M_CSN=0, M_WEN=1, M_BE=4'hF.
    - D grant: M_CSN=0, M_WEN=~D_WE, M_BE=D_BE, M_DI=D_WDATA.
    - M_ADDR takes the granted port's address in both cases.
  - With no grant, M_CSN=1 and the other M_* registers hold their values.
- A 2-bit tag register (src, is_read) travels with the command.
- Stage R (response, edge ending cycle N+1):
  - If the tag is a read, M_DOUT is captured into that port's RDATA.
  - That port's RVALID is high in cycle N+2.
- Writes produce no RVALID. A write is complete once the SRAM access in cycle N+1 is done.
- A D write with D_BE=4'h0 is granted and issued normally; memory content is unchanged.
- No response back-pressure: requesters must accept RVALID whenever it arrives.
- Ordering: accesses execute in grant order, one per cycle.
  - A read granted the cycle after a write to the same address returns the new data.
- Reset, asynchronous:
  - M_CSN=1, M_WEN=1, M_ADDR=0, M_BE=0, M_DI=0.
  - I_RVALID=D_RVALID=0, I_RDATA=D_RDATA=0, tag cleared, LAST=I.
  - Any in-flight command is dropped.
  - GNT outputs are 0 while RST is high.

## Timing
- Grant is combinational in the request cycle.
- Read latency: request cycle N → RVALID in cycle N+2.
- Write is performed in cycle N+1.
- Throughput is one access per cycle total. Under continuous conflict each port gets every other cycle.
- M_* outputs change only at clock edges (or asynchronously on reset), never combinationally from requester inputs.
- Deassertion of RST: the first grant is possible in the first cycle RST is low.

## Test plan
- Reset: with RST high, drive I_REQ=D_REQ=1 → M_CSN=1, I_GNT=D_GNT=0, both RVALID=0, both RDATA=0.
- Single read: preload word 0x010=0xDEADBEEF, I_REQ with I_ADDR=0x010 in cycle 0 → I_GNT in cycle 0, M_CSN=0/M_WEN=1 in cycle 1, I_RVALID=1 with I_RDATA=0xDEADBEEF in cycle 2.
- Byte write then read:
  - Word 0x020=0x11223344; D write D_BE=4'b0101, D_WDATA=0xAABBCCDD, followed back-to-back by a D read of 0x020.
  - Required: D_RVALID two cycles after the read grant with D_RDATA=0x11BB33DD, and no D_RVALID for the write.
- Conflict round-robin: I_REQ and D_REQ both held high for 4 cycles after reset → grants D,I,D,I; four responses arrive in the same order, each two cycles after its grant.
- Read-after-write hazard: D write 0x5A5A5A5A to 0x030 granted in cycle 0, I read of 0x030 granted in cycle 1 → I_RDATA=0x5A5A5A5A in cycle 3.
- Reset mid-operation: assert RST asynchronously in the cycle after a read grant → M_CSN goes to 1 immediately, no RVALID ever appears for that read, and the next request after reset behaves as in the single-read case.
